// File: rtl/detector_jogada.sv
// Button front end: 2-FF synchroniser, press/release debounce FSM and one-hot press encoder.
// Optional macro DETECTOR_REJEITA_MULTIPLO_EN: multi-bit samples raise erro_multiplo only, no press.
module detector_jogada #(
   parameter int unsigned N_BOTOES        = 4,
   parameter int unsigned DEBOUNCE_CICLOS = 20
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                enable,
   input  logic [N_BOTOES-1:0] botoes,
   output logic [N_BOTOES-1:0] jogada,
   output logic                jogada_feita,
   output logic                tem_jogada,
   output logic                erro_multiplo
);

   localparam int unsigned      CW      = $clog2(DEBOUNCE_CICLOS);
   localparam logic [CW-1:0]    CNT_MAX = CW'(DEBOUNCE_CICLOS - 1);

   typedef enum logic [1:0] {
      OCIOSO,
      FILTRANDO,
      ACEITO,
      ESPERA_SOLTAR
   } estado_t;

   estado_t             estado_q, estado_d;
   logic [N_BOTOES-1:0] sync1_q, s_q;
   logic [N_BOTOES-1:0] amostra_q, amostra_d;
   logic [N_BOTOES-1:0] jogada_q, jogada_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                feita_q, feita_d;
   logic                erro_q, erro_d;
   logic                tem_q, tem_d;
   logic                multiplo;

   always_comb begin
      multiplo  = ($countones(amostra_q) > 1);
      estado_d  = estado_q;
      cnt_d     = cnt_q;
      amostra_d = amostra_q;
      jogada_d  = jogada_q;
      feita_d   = 1'b0;
      erro_d    = 1'b0;
      // Outputs are registered from the current state, so they trail it by one cycle.
      tem_d     = (estado_q != OCIOSO);

      case (estado_q)
         OCIOSO: begin
            if (enable && (s_q != '0)) begin
               amostra_d = s_q;
               cnt_d     = '0;
               estado_d  = FILTRANDO;
            end
         end
         FILTRANDO: begin
            if (!enable || (s_q != amostra_q)) begin
               cnt_d    = '0;
               estado_d = OCIOSO;
            end else if (cnt_q == CNT_MAX) begin
               cnt_d    = '0;
               estado_d = ACEITO;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ACEITO: begin
            erro_d = multiplo;
`ifdef DETECTOR_REJEITA_MULTIPLO_EN
            if (!multiplo) begin
               feita_d  = 1'b1;
               jogada_d = amostra_q;
            end
`else
            feita_d  = 1'b1;
            jogada_d = amostra_q;
`endif
            cnt_d    = '0;
            estado_d = ESPERA_SOLTAR;
         end
         ESPERA_SOLTAR: begin
            if (s_q != '0) begin
               cnt_d = '0;
            end else if (cnt_q == CNT_MAX) begin
               cnt_d    = '0;
               estado_d = OCIOSO;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            cnt_d    = '0;
            estado_d = OCIOSO;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         estado_q  <= OCIOSO;
         sync1_q   <= '0;
         s_q       <= '0;
         amostra_q <= '0;
         jogada_q  <= '0;
         cnt_q     <= '0;
         feita_q   <= 1'b0;
         erro_q    <= 1'b0;
         tem_q     <= 1'b0;
      end else begin
         estado_q  <= estado_d;
         sync1_q   <= botoes;
         s_q       <= sync1_q;
         amostra_q <= amostra_d;
         jogada_q  <= jogada_d;
         cnt_q     <= cnt_d;
         feita_q   <= feita_d;
         erro_q    <= erro_d;
         tem_q     <= tem_d;
      end
   end

   assign jogada        = jogada_q;
   assign jogada_feita  = feita_q;
   assign tem_jogada    = tem_q;
   assign erro_multiplo = erro_q;

endmodule

// File: tb/tb_detector_jogada.sv
// Directed bench for detector_jogada with DEBOUNCE_CICLOS=4; press latency is 7 edges.
module tb_detector_jogada;

   logic       clock = 1'b0;
   logic       reset;
   logic       enable;
   logic [3:0] botoes;
   logic [3:0] jogada;
   logic       jogada_feita;
   logic       tem_jogada;
   logic       erro_multiplo;

   int n_vec = 0;
   int n_err = 0;

   detector_jogada #(
      .N_BOTOES       (4),
      .DEBOUNCE_CICLOS(4)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .enable       (enable),
      .botoes       (botoes),
      .jogada       (jogada),
      .jogada_feita (jogada_feita),
      .tem_jogada   (tem_jogada),
      .erro_multiplo(erro_multiplo)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_jogada"}, 32'(jogada), 32'h0);
      check({tag, "_feita"}, 32'(jogada_feita), 32'h0);
      check({tag, "_tem"}, 32'(tem_jogada), 32'h0);
      check({tag, "_erro"}, 32'(erro_multiplo), 32'h0);
   endtask

   // Hold val for n edges from an idle detector; pulses expected at the given edge (-1: none).
   task automatic aperta(input logic [3:0] val, input int n, input int feita_at,
                         input int erro_at, input logic [3:0] exp_jog, input string tag);
      botoes = val;
      for (int i = 0; i < n; i++) begin
         tick();
         check($sformatf("%s_feita_e%0d", tag, i), 32'(jogada_feita), 32'(i == feita_at));
         check($sformatf("%s_erro_e%0d", tag, i), 32'(erro_multiplo), 32'(i == erro_at));
         if (i == 2) check($sformatf("%s_tem_e2", tag), 32'(tem_jogada), 32'h0);
         if (i == 3) check($sformatf("%s_tem_e3", tag), 32'(tem_jogada), 32'h1);
      end
      check({tag, "_jogada"}, 32'(jogada), 32'(exp_jog));
   endtask

   task automatic soltar(input string tag, input logic [3:0] exp_jog);
      botoes = 4'b0000;
      for (int i = 0; i < 10; i++) begin
         tick();
         check($sformatf("%s_feita_e%0d", tag, i), 32'(jogada_feita), 32'h0);
      end
      check({tag, "_tem"}, 32'(tem_jogada), 32'h0);
      check({tag, "_jogada"}, 32'(jogada), 32'(exp_jog));
   endtask

   task automatic segura_sem_pulso(input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         tick();
         check($sformatf("%s_feita_e%0d", tag, i), 32'(jogada_feita), 32'h0);
      end
   endtask

   initial begin
      logic [3:0] jog_multi;
      int         feita_multi;

      reset  = 1'b1;
      enable = 1'b1;
      botoes = 4'b1111;
      repeat (3) tick();
      check_zero("reset_inicial");
      reset = 1'b0;

`ifdef DETECTOR_REJEITA_MULTIPLO_EN
      aperta(4'b1111, 10, -1, 7, 4'b0000, "pos_reset_1111");
      soltar("solta_1111", 4'b0000);
`else
      aperta(4'b1111, 10, 7, 7, 4'b1111, "pos_reset_1111");
      soltar("solta_1111", 4'b1111);
`endif

      aperta(4'b0100, 12, 7, -1, 4'b0100, "press_0100");
      soltar("solta_0100", 4'b0100);

      // Bounce: two cycles high, one low, then steady.
      botoes = 4'b0010;
      segura_sem_pulso(2, "bounce_a");
      botoes = 4'b0000;
      segura_sem_pulso(1, "bounce_b");
      aperta(4'b0010, 40, 7, -1, 4'b0010, "bounce_firme");
      botoes = 4'b0000;
      segura_sem_pulso(4, "solta4");
      aperta(4'b0001, 12, 7, -1, 4'b0001, "press_0001");
      soltar("solta_0001", 4'b0001);

      enable = 1'b0;
      botoes = 4'b1000;
      segura_sem_pulso(12, "enable0");
      check("enable0_tem", 32'(tem_jogada), 32'h0);
      soltar("solta_enable0", 4'b0001);

      enable = 1'b1;
      botoes = 4'b1000;
      segura_sem_pulso(4, "aborta_a");
      enable = 1'b0;
      segura_sem_pulso(8, "aborta_b");
      check("aborta_tem", 32'(tem_jogada), 32'h0);
      soltar("solta_aborta", 4'b0001);

      enable = 1'b1;
      aperta(4'b0100, 10, 7, -1, 4'b0100, "press_espera");
      enable = 1'b0;
      soltar("solta_enable_baixo", 4'b0100);
      enable = 1'b1;
      aperta(4'b1000, 12, 7, -1, 4'b1000, "press_1000");
      soltar("solta_1000", 4'b1000);

`ifdef DETECTOR_REJEITA_MULTIPLO_EN
      feita_multi = -1;
      jog_multi   = 4'b1000;
`else
      feita_multi = 7;
      jog_multi   = 4'b0011;
`endif
      aperta(4'b0011, 12, feita_multi, 7, jog_multi, "press_0011");
      soltar("solta_0011", jog_multi);

      botoes = 4'b0010;
      segura_sem_pulso(4, "rst_filtrando_a");
      reset = 1'b1;
      tick();
      check_zero("rst_filtrando");
      reset = 1'b0;
      aperta(4'b0010, 12, 7, -1, 4'b0010, "apos_rst_filtrando");

      reset = 1'b1;
      tick();
      check_zero("rst_espera");
      reset = 1'b0;
      aperta(4'b0010, 12, 7, -1, 4'b0010, "apos_rst_espera");
      soltar("solta_final", 4'b0010);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
